// File: rtl/sync_stream_fifo_if.sv
// Valid/ready stream bundle used on both sides of sync_stream_fifo.
// The master drives valid and data. The slave answers with ready.
interface sync_stream_fifo_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sync_stream_fifo.sv
// Single-clock show-ahead stream FIFO with a registered output word, a fill level,
// almost-full/almost-empty flags and a synchronous flush.
module sync_stream_fifo #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned ALMOST_FULL  = 0,
   parameter int unsigned ALMOST_EMPTY = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   sync_stream_fifo_if.slave       in_stream,
   sync_stream_fifo_if.master      out_stream,
   output logic                    in_almost_full,
   output logic                    out_almost_empty,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [LW-1:0] lvl_t;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_stream_fifo: DEPTH must be a power of two >= 2");
   end
   if (ALMOST_FULL > DEPTH || ALMOST_EMPTY > DEPTH) begin : g_bad_thresh
      $error("sync_stream_fifo: ALMOST_FULL/ALMOST_EMPTY must not exceed DEPTH");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   ptr_t             wr_ptr_q, rd_ptr_q;
   lvl_t             level_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;

   logic full, push, pop, mem_has_data, mem_we, mem_re, load_direct;

   always_comb begin
      full         = (level_q == lvl_t'(DEPTH));
      push         = in_stream.valid & ~full;
      pop          = out_valid_q & out_stream.ready;
      // Words parked in the array behind the output register.
      mem_has_data = (level_q > lvl_t'(out_valid_q));
      mem_re       = ~flush & pop & mem_has_data;
      // A push bypasses the array when the output register is (or is about to be) free.
      load_direct  = ~flush & push & (~out_valid_q | (pop & ~mem_has_data));
      mem_we       = ~flush & push & ~load_direct;
   end

   assign in_stream.ready   = ~full;
   assign out_stream.valid  = out_valid_q;
   assign out_stream.data   = out_data_q;
   assign level             = level_q;
   assign in_almost_full    = (lvl_t'(DEPTH) - level_q) <= lvl_t'(ALMOST_FULL);
   assign out_almost_empty  = level_q <= lvl_t'(ALMOST_EMPTY);

   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[wr_ptr_q] <= in_stream.data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (flush) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (mem_we) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (mem_re) begin
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            out_data_q <= mem[rd_ptr_q];
         end else if (load_direct) begin
            out_data_q  <= in_stream.data;
            out_valid_q <= 1'b1;
         end else if (pop) begin
            out_valid_q <= 1'b0;
         end
         if (push && !pop) begin
            level_q <= level_q + 1'b1;
         end else if (pop && !push) begin
            level_q <= level_q - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sync_stream_fifo.sv
// Bench for sync_stream_fifo: vector table, directed corner sequences and random traffic
// compared against a queue-based model of the FIFO.
module tb_sync_stream_fifo;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AF    = 2;
   localparam int unsigned AE    = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       flush = 1'b0;
   logic       in_almost_full;
   logic       out_almost_empty;
   logic [3:0] level;

   sync_stream_fifo_if #(.WIDTH(WIDTH)) in_stream ();
   sync_stream_fifo_if #(.WIDTH(WIDTH)) out_stream ();

   sync_stream_fifo #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
   ) dut (
      .clock(clock),
      .reset(reset),
      .flush(flush),
      .in_stream(in_stream),
      .out_stream(out_stream),
      .in_almost_full(in_almost_full),
      .out_almost_empty(out_almost_empty),
      .level(level)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   logic [7:0] model_q[$];

   typedef struct {
      bit         in_valid;
      logic [7:0] in_data;
      bit         out_ready;
      int         exp_level;
      bit         exp_ready;
      bit         exp_valid;
      logic [7:0] exp_data;
      bit         exp_af;
   } vec_t;
   vec_t vecs[17];

   task automatic cmp(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      int n;
      n = model_q.size();
      cmp({tag, " level"}, int'(level), n);
      cmp({tag, " in_ready"}, int'(in_stream.ready), int'(n != DEPTH));
      cmp({tag, " out_valid"}, int'(out_stream.valid), int'(n > 0));
      if (n > 0) cmp({tag, " out_data"}, int'(out_stream.data), int'(model_q[0]));
      cmp({tag, " almost_full"}, int'(in_almost_full), int'((DEPTH - n) <= AF));
      cmp({tag, " almost_empty"}, int'(out_almost_empty), int'(n <= AE));
   endtask

   // One clock edge, with the model advanced from the inputs held across that edge.
   task automatic tick();
      bit push, pop;
      push = in_stream.valid && (model_q.size() != DEPTH);
      pop  = (model_q.size() > 0) && out_stream.ready;
      @(posedge clock);
      if (flush) begin
         model_q.delete();
      end else begin
         if (pop) void'(model_q.pop_front());
         if (push) model_q.push_back(in_stream.data);
      end
      #1;
   endtask

   task automatic drive(input bit v, input logic [7:0] d, input bit r);
      in_stream.valid  = v;
      in_stream.data   = d;
      out_stream.ready = r;
   endtask

   initial begin
      for (int i = 0; i < 9; i++) begin
         int l;
         l = (i + 1 > 8) ? 8 : i + 1;
         vecs[i].in_valid  = 1'b1;
         vecs[i].in_data   = 8'(i + 1);
         vecs[i].out_ready = 1'b0;
         vecs[i].exp_level = l;
         vecs[i].exp_ready = (l != 8);
         vecs[i].exp_valid = 1'b1;
         vecs[i].exp_data  = 8'h01;
         vecs[i].exp_af    = ((8 - l) <= 2);
      end
      for (int i = 0; i < 8; i++) begin
         int l;
         l = 7 - i;
         vecs[9 + i].in_valid  = 1'b0;
         vecs[9 + i].in_data   = 8'hEE;
         vecs[9 + i].out_ready = 1'b1;
         vecs[9 + i].exp_level = l;
         vecs[9 + i].exp_ready = 1'b1;
         vecs[9 + i].exp_valid = (l > 0);
         vecs[9 + i].exp_data  = 8'(i + 2);
         vecs[9 + i].exp_af    = ((8 - l) <= 2);
      end

      drive(1'b1, 8'h77, 1'b1);
      #12;
      cmp("reset level", int'(level), 0);
      cmp("reset out_valid", int'(out_stream.valid), 0);
      cmp("reset out_data", int'(out_stream.data), 0);
      cmp("reset almost_empty", int'(out_almost_empty), 1);
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      tick();
      cmp("post-reset in_ready", int'(in_stream.ready), 1);
      cmp("post-reset almost_full", int'(in_almost_full), 0);
      check_model("post-reset");

      // Fill to full, refuse a ninth word, then drain in order.
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
         tick();
         cmp($sformatf("vec%0d level", i), int'(level), vecs[i].exp_level);
         cmp($sformatf("vec%0d in_ready", i), int'(in_stream.ready), int'(vecs[i].exp_ready));
         cmp($sformatf("vec%0d out_valid", i), int'(out_stream.valid), int'(vecs[i].exp_valid));
         if (vecs[i].exp_valid)
            cmp($sformatf("vec%0d out_data", i), int'(out_stream.data), int'(vecs[i].exp_data));
         cmp($sformatf("vec%0d almost_full", i), int'(in_almost_full), int'(vecs[i].exp_af));
      end

      // Single word latency through an empty FIFO.
      drive(1'b1, 8'hA5, 1'b1);
      tick();
      cmp("lat out_valid", int'(out_stream.valid), 1);
      cmp("lat out_data", int'(out_stream.data), 'hA5);
      cmp("lat level", int'(level), 1);
      drive(1'b0, 8'h00, 1'b1);
      tick();
      cmp("lat drained", int'(out_stream.valid), 0);
      cmp("lat level0", int'(level), 0);

      // Streaming: one word per cycle, level pinned at 1.
      for (int j = 0; j < 40; j++) begin
         drive(1'b1, 8'(8'h80 + j), 1'b1);
         tick();
         cmp($sformatf("stream%0d level", j), int'(level), 1);
         cmp($sformatf("stream%0d out_data", j), int'(out_stream.data), 8'h80 + j);
      end
      drive(1'b0, 8'h00, 1'b1);
      tick();
      check_model("stream end");

      // Full with both sides enabled: first edge pops only.
      for (int j = 0; j < 8; j++) begin
         drive(1'b1, 8'(8'h40 + j), 1'b0);
         tick();
      end
      drive(1'b1, 8'h50, 1'b1);
      #1;
      cmp("full in_ready w/ out_ready", int'(in_stream.ready), 0);
      for (int k = 0; k < 6; k++) begin
         in_stream.data = 8'(8'h50 + k);
         tick();
         cmp($sformatf("full%0d level", k), int'(level), 7);
         cmp($sformatf("full%0d out_data", k), int'(out_stream.data), 8'h41 + k);
         check_model($sformatf("full%0d", k));
      end
      drive(1'b0, 8'h00, 1'b1);
      for (int k = 0; k < 10; k++) begin
         tick();
         check_model("drain");
      end

      // Flush beats a simultaneous push and pop.
      for (int j = 0; j < 5; j++) begin
         drive(1'b1, 8'(8'h60 + j), 1'b0);
         tick();
      end
      cmp("preflush level", int'(level), 5);
      drive(1'b1, 8'h99, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      cmp("flush level", int'(level), 0);
      cmp("flush out_valid", int'(out_stream.valid), 0);
      cmp("flush almost_empty", int'(out_almost_empty), 1);
      cmp("flush in_ready", int'(in_stream.ready), 1);
      drive(1'b0, 8'h00, 1'b0);
      tick();
      cmp("postflush level", int'(level), 0);

      // Asynchronous reset between edges with three words held.
      for (int j = 0; j < 3; j++) begin
         drive(1'b1, 8'(8'h20 + j), 1'b0);
         tick();
      end
      #2;
      reset = 1'b0;
      model_q.delete();
      #1;
      cmp("async rst out_valid", int'(out_stream.valid), 0);
      cmp("async rst level", int'(level), 0);
      drive(1'b1, 8'h77, 1'b1);
      @(posedge clock);
      #1;
      cmp("rst hold level", int'(level), 0);
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      drive(1'b1, 8'h3C, 1'b0);
      tick();
      cmp("rst push out_data", int'(out_stream.data), 'h3C);
      cmp("rst push level", int'(level), 1);
      drive(1'b0, 8'h00, 1'b1);
      tick();
      cmp("rst pop out_valid", int'(out_stream.valid), 0);
      check_model("rst pop");

      // Random traffic with phase-varying bias so the FIFO fills, empties and wraps.
      for (int c = 0; c < 3000; c++) begin
         int pv, pr;
         pv = ((c / 200) % 2 == 0) ? 75 : 35;
         pr = ((c / 200) % 2 == 0) ? 35 : 75;
         drive($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pr);
         flush = ($urandom_range(0, 127) == 0);
         tick();
         check_model("rand");
      end
      flush = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
